// File: rtl/clk_burst_ctrl.sv
// Burst clock generator: emits 2*count toggles of a divided clock starting and ending at cpol,
// with registered lead/trail edge strobes, busy flag and a completion strobe.
module clk_burst_ctrl #(
    parameter int unsigned DIVW = 8,
    parameter int unsigned CNTW = 6
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [DIVW-1:0] half_div,
    input  logic [CNTW-1:0] count,
    input  logic            cpol,
    output logic            clk_o,
    output logic            lead_o,
    output logic            trail_o,
    output logic            busy,
    output logic            done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [DIVW-1:0] DivOne = DIVW'(1);
    localparam logic [CNTW:0]   RemOne = (CNTW + 1)'(1);

    state_e          state_q, state_d;
    logic [DIVW-1:0] hd_q, hd_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [CNTW:0]   rem_q, rem_d;
    logic            pol_q, pol_d;
    logic            clk_q, clk_d;
    logic            lead_q, lead_d;
    logic            trail_q, trail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            toggle;

    always_comb begin
        state_d = state_q;
        hd_d    = hd_q;
        div_d   = div_q;
        rem_d   = rem_q;
        pol_d   = pol_q;
        clk_d   = clk_q;
        lead_d  = 1'b0;
        trail_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        toggle  = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_d  = cpol;
                busy_d = 1'b0;
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        hd_d    = (half_div == '0) ? DivOne : half_div;
                        pol_d   = cpol;
                        div_d   = '0;
                        rem_d   = {count, 1'b0};
                        busy_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    clk_d   = pol_q;
                    busy_d  = 1'b0;
                    div_d   = '0;
                    rem_d   = '0;
                end else begin
                    toggle = (div_q == hd_q - DivOne);
                    if (toggle) begin
                        div_d   = '0;
                        clk_d   = ~clk_q;
                        lead_d  = (~clk_q != pol_q);
                        trail_d = (~clk_q == pol_q);
                        rem_d   = rem_q - RemOne;
                        if (rem_q == RemOne) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        div_d = div_q + DivOne;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hd_q    <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            pol_q   <= 1'b0;
            clk_q   <= 1'b0;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hd_q    <= hd_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            pol_q   <= pol_d;
            clk_q   <= clk_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clk_o   = clk_q;
    assign lead_o  = lead_q;
    assign trail_o = trail_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Self-checking bench for clk_burst_ctrl: vector table, directed corner sequences and random
// stimulus against a schedule-based reference model.
module tb_clk_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, cpol;
    logic [7:0] half_div;
    logic [5:0] count;
    logic       clk_o, lead_o, trail_o, busy, done;

    clk_burst_ctrl #(.DIVW(8), .CNTW(6)) dut (
        .clk_i   (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .half_div(half_div),
        .count   (count),
        .cpol    (cpol),
        .clk_o   (clk_o),
        .lead_o  (lead_o),
        .trail_o (trail_o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_lead, n_trail, n_done, n_busy;
    logic [4:0] got;

    // Model: a burst accepted at edge 0 toggles at edges hd, 2hd, ... 2*cnt*hd.
    bit         m_act = 1'b0;
    int         m_e, m_hd, m_cnt;
    bit         m_pol;
    logic [4:0] m_exp = 5'b0;   // {clk_o, lead_o, trail_o, busy, done}

    task automatic model_edge(input logic s, input logic a, input logic r,
                              input logic [7:0] hd, input logic [5:0] c, input logic p);
        int k;
        if (r) begin
            m_act = 1'b0;
            m_exp = 5'b0;
        end else if (m_act) begin
            if (a) begin
                m_act = 1'b0;
                m_exp = {m_pol, 4'b0000};
            end else begin
                m_e++;
                k = m_e / m_hd;
                if (k >= 2 * m_cnt) begin
                    m_act = 1'b0;
                    m_exp = {m_pol, 1'b0, 1'b1, 1'b0, 1'b1};
                end else if (m_e % m_hd == 0) begin
                    m_exp = {m_pol ^ k[0], k[0], ~k[0], 1'b1, 1'b0};
                end else begin
                    m_exp = {m_pol ^ k[0], 4'b0010};
                end
            end
        end else begin
            m_exp = {p, 4'b0000};
            if (s && !a) begin
                if (c == 0) begin
                    m_exp[0] = 1'b1;
                end else begin
                    m_act    = 1'b1;
                    m_e      = 0;
                    m_hd     = (hd == 0) ? 1 : int'(hd);
                    m_cnt    = int'(c);
                    m_pol    = p;
                    m_exp[1] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Called at a negedge: drive, clock, then compare against the model at the next negedge.
    task automatic step(input logic s, input logic a, input logic r, input logic [7:0] hd,
                        input logic [5:0] c, input logic p, input string name);
        start = s; abort = a; rst = r; half_div = hd; count = c; cpol = p;
        @(posedge clk);
        model_edge(s, a, r, hd, c, p);
        @(negedge clk);
        got = {clk_o, lead_o, trail_o, busy, done};
        checks++;
        if (got !== m_exp) begin
            errors++;
            $display("FAIL %s: got clk/lead/trail/busy/done=%b expected %b", name, got, m_exp);
        end
        n_lead  += int'(lead_o);
        n_trail += int'(trail_o);
        n_done  += int'(done);
        n_busy  += int'(busy);
    endtask

    task automatic clr_cnt();
        n_lead = 0; n_trail = 0; n_done = 0; n_busy = 0;
    endtask

    typedef struct {
        logic       s, a;
        logic [7:0] hd;
        logic [5:0] c;
        logic       p;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1, 0, 8'd1, 6'd1, 0, 5'b00010};  // accept: busy
        vecs[1]  = '{0, 0, 8'd1, 6'd1, 0, 5'b11010};  // lead
        vecs[2]  = '{0, 0, 8'd1, 6'd1, 0, 5'b00101};  // trail + done
        vecs[3]  = '{0, 0, 8'd1, 6'd1, 0, 5'b00000};
        vecs[4]  = '{1, 0, 8'd5, 6'd0, 0, 5'b00001};  // count=0: done only
        vecs[5]  = '{0, 0, 8'd5, 6'd0, 0, 5'b00000};
        vecs[6]  = '{0, 0, 8'd5, 6'd0, 1, 5'b10000};  // idle follows cpol
        vecs[7]  = '{1, 1, 8'd1, 6'd2, 1, 5'b10000};  // start+abort in idle: ignored
        vecs[8]  = '{0, 0, 8'd1, 6'd2, 1, 5'b10000};
        vecs[9]  = '{1, 0, 8'd0, 6'd1, 1, 5'b10010};  // half_div=0 acts as 1
        vecs[10] = '{0, 0, 8'd0, 6'd1, 0, 5'b01010};  // lead (away from latched 1)
        vecs[11] = '{0, 0, 8'd0, 6'd1, 0, 5'b10101};  // trail + done, cpol change ignored
        vecs[12] = '{0, 0, 8'd0, 6'd1, 0, 5'b00000};

        clr_cnt();
        rst = 1'b1; start = 1'b0; abort = 1'b0; half_div = 8'd1; count = 6'd1; cpol = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({clk_o, lead_o, trail_o, busy, done}), 0);

        // First edge after release loads cpol
        step(0, 0, 0, 8'd1, 6'd1, 1, "rst_release");
        chk("rst_release_clk", int'(clk_o), 1);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].s, vecs[i].a, 1'b0, vecs[i].hd, vecs[i].c, vecs[i].p, "table_model");
            chk($sformatf("table_%0d", i), int'(got), int'(vecs[i].exp));
        end

        // cpol=1, hd=3, count=4: 8 toggles, 4 leads, 4 trails, 1 done, 24 busy cycles
        clr_cnt();
        step(1, 0, 0, 8'd3, 6'd4, 1, "b34");
        for (int i = 0; i < 26; i++) step(0, 0, 0, 8'd9, 6'd1, 0, "b34");
        chk("b34_leads", n_lead, 4);
        chk("b34_trails", n_trail, 4);
        chk("b34_done", n_done, 1);
        chk("b34_busy", n_busy, 24);

        // half_div=0, count=2: 4 toggles on consecutive cycles
        clr_cnt();
        step(1, 0, 0, 8'd0, 6'd2, 0, "b35");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'd0, 6'd2, 0, "b35");
        chk("b35_busy", n_busy, 4);
        chk("b35_done", n_done, 1);

        // Abort after the third toggle of a count=3, hd=2 burst
        clr_cnt();
        step(1, 0, 0, 8'd2, 6'd3, 0, "b36");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'd2, 6'd3, 0, "b36");
        chk("b36_pre_abort_clk", int'(clk_o), 1);
        step(0, 1, 0, 8'd2, 6'd3, 0, "b36_abort");
        chk("b36_abort_clk", int'(clk_o), 0);
        chk("b36_abort_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd2, 6'd3, 0, "b36");
        chk("b36_no_done", n_done, 0);
        clr_cnt();
        step(1, 0, 0, 8'd2, 6'd3, 0, "b36_rerun");
        for (int i = 0; i < 13; i++) step(0, 0, 0, 8'd2, 6'd3, 0, "b36_rerun");
        chk("b36_rerun_done", n_done, 1);
        chk("b36_rerun_leads", n_lead, 3);

        // start held: back-to-back bursts, one done every 5 cycles
        clr_cnt();
        for (int i = 0; i < 20; i++) step(1, 0, 0, 8'd1, 6'd2, 0, "b37");
        chk("b37_done", n_done, 4);
        chk("b37_busy", n_busy, 16);
        step(0, 0, 0, 8'd1, 6'd2, 0, "b37_tail");

        // rst mid-burst
        clr_cnt();
        step(1, 0, 0, 8'd2, 6'd3, 1, "b38");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd2, 6'd3, 1, "b38");
        rst = 1'b1;
        #1;
        chk("b38_async_rst", int'({clk_o, lead_o, trail_o, busy, done}), 0);
        @(negedge clk);
        step(0, 0, 1, 8'd2, 6'd3, 1, "b38_in_rst");
        step(0, 0, 0, 8'd2, 6'd3, 1, "b38_release");
        chk("b38_release_clk", int'(clk_o), 1);
        chk("b38_no_done", n_done, 0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(2) == 0), ($urandom_range(19) == 0), ($urandom_range(199) == 0),
                 8'($urandom_range(3)), 6'($urandom_range(3)), 1'($urandom_range(1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
